// File: rtl/periodic_update_gen.sv
// Periodic value generator: every eff_period enabled cycles the value is
// transformed by the selected mode (invert / rotate-left / increment / hold).
module periodic_update_gen #(
   parameter int unsigned           WIDTH    = 4,
   parameter int unsigned           PERIOD_W = 8,
   parameter logic [WIDTH-1:0]      INIT     = WIDTH'('h5)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   input  logic [1:0]          mode,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_val,
   output logic [WIDTH-1:0]    value,
   output logic                tick,
   output logic [7:0]          upd_count
);

   localparam int unsigned UPD_W = 8;

   localparam logic [1:0] MODE_INV  = 2'b00;
   localparam logic [1:0] MODE_ROTL = 2'b01;
   localparam logic [1:0] MODE_INC  = 2'b10;

   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_nxt;
   logic [PERIOD_W-1:0] last_cnt_c;
   logic                terminal_c;
   logic [WIDTH-1:0]    op_val_c;
   logic [WIDTH-1:0]    value_nxt;
   logic                tick_nxt;
   logic [UPD_W-1:0]    upd_count_nxt;

   // Period 0 behaves as 1; >= keeps a shrinking period from wrapping cnt.
   always_comb begin
      last_cnt_c = '0;
      if (period != '0) begin
         last_cnt_c = period - PERIOD_W'(1);
      end
      terminal_c = en && (cnt >= last_cnt_c);
   end

   // Mode operation applied on an update edge
   always_comb begin
      op_val_c = value;
      case (mode)
         MODE_INV:  op_val_c = ~value;
         MODE_ROTL: op_val_c = (value << 1) | (value >> (WIDTH - 1));
         MODE_INC:  op_val_c = value + WIDTH'(1);
         default:   op_val_c = value;
      endcase
   end

   // Next-state: load beats update; en low freezes everything
   always_comb begin
      cnt_nxt       = cnt;
      value_nxt     = value;
      tick_nxt      = 1'b0;
      upd_count_nxt = upd_count;
      if (load) begin
         value_nxt = load_val;
         cnt_nxt   = '0;
      end else if (terminal_c) begin
         value_nxt     = op_val_c;
         cnt_nxt       = '0;
         tick_nxt      = 1'b1;
         upd_count_nxt = upd_count + UPD_W'(1);
      end else if (en) begin
         cnt_nxt = cnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         value     <= INIT;
         tick      <= 1'b0;
         upd_count <= '0;
      end else begin
         cnt       <= cnt_nxt;
         value     <= value_nxt;
         tick      <= tick_nxt;
         upd_count <= upd_count_nxt;
      end
   end

endmodule

// File: tb/tb_periodic_update_gen.sv
// Bench for periodic_update_gen: vector table plus scenario sequences, with
// per-cycle expectations queued by a behavioural reference model.
module tb_periodic_update_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] period;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] value;
   logic       tick;
   logic [7:0] upd_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] v;
      logic       t;
      logic [7:0] u;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       en;
      logic       ld;
      logic [7:0] per;
      logic [1:0] md;
      logic [3:0] lv;
      logic [3:0] ev;
      logic       et;
      logic [7:0] eu;
   } vec_t;

   exp_t exp_q[$];

   // reference model state
   logic [3:0] m_v;
   int         m_c;
   logic       m_t;
   logic [7:0] m_u;

   periodic_update_gen #(.WIDTH(4), .PERIOD_W(8), .INIT(4'h5)) dut (
      .clk(clk), .reset(reset), .en(en), .period(period), .mode(mode),
      .load(load), .load_val(load_val), .value(value), .tick(tick),
      .upd_count(upd_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic rst, input logic e, input logic ld, input logic [7:0] per,
                        input logic [1:0] md, input logic [3:0] lv);
      int eff;
      eff = (per == 8'd0) ? 1 : int'(per);
      if (rst) begin
         m_v = 4'h5; m_c = 0; m_t = 1'b0; m_u = 8'd0;
      end else if (ld) begin
         m_v = lv; m_c = 0; m_t = 1'b0;
      end else if (e && (m_c + 1 >= eff)) begin
         case (md)
            2'b00: m_v = ~m_v;
            2'b01: m_v = {m_v[2:0], m_v[3]};
            2'b10: m_v = m_v + 4'd1;
            default: ;
         endcase
         m_c = 0; m_t = 1'b1; m_u = m_u + 8'd1;
      end else begin
         m_t = 1'b0;
         if (e) m_c = m_c + 1;
      end
   endtask

   // Drive one cycle, queue the model's expectation, compare after the edge
   task automatic cycle(input string name, input logic rst, input logic e, input logic ld,
                        input logic [7:0] per, input logic [1:0] md, input logic [3:0] lv);
      exp_t x;
      @(negedge clk);
      reset = rst; en = e; load = ld; period = per; mode = md; load_val = lv;
      model(rst, e, ld, per, md, lv);
      exp_q.push_back('{v: m_v, t: m_t, u: m_u});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s_sb: scoreboard empty, got value 0x%0h expected an entry", name, value);
      end else begin
         x = exp_q.pop_front();
         chk({name, "_value"}, 32'(value), 32'(x.v));
         chk({name, "_tick"}, 32'(tick), 32'(x.t));
         chk({name, "_upd"}, 32'(upd_count), 32'(x.u));
      end
   endtask

   task automatic do_reset(input string name);
      cycle(name, 1'b1, 1'b0, 1'b0, 8'd10, 2'b00, 4'h0);
   endtask

   initial begin
      vec_t vecs[13];
      reset = 1'b1; en = 1'b0; load = 1'b0; period = 8'd10; mode = 2'b00; load_val = 4'h0;
      m_v = 4'h0; m_c = 0; m_t = 1'b0; m_u = 8'd0;

      // rst  en  ld   per  md   lv    ev    et  eu
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd1, 2'b01, 4'h0, 4'h5, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd1, 2'b01, 4'h9, 4'h9, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b01, 4'h0, 4'h3, 1'b1, 8'd1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b01, 4'h0, 4'h6, 1'b1, 8'd2};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b01, 4'h0, 4'hC, 1'b1, 8'd3};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b01, 4'h0, 4'h9, 1'b1, 8'd4};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd1, 2'b01, 4'h0, 4'h9, 1'b0, 8'd4};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b11, 4'h0, 4'h9, 1'b1, 8'd5};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b00, 4'h0, 4'h6, 1'b1, 8'd6};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 2'b10, 4'h0, 4'h7, 1'b1, 8'd7};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd1, 2'b10, 4'hF, 4'hF, 1'b0, 8'd7};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd1, 2'b10, 4'h0, 4'h0, 1'b1, 8'd8};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 8'd1, 2'b10, 4'hA, 4'h5, 1'b0, 8'd0};

      for (int i = 0; i < 13; i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].ld,
               vecs[i].per, vecs[i].md, vecs[i].lv);
         chk($sformatf("vec%0d_tv", i), 32'(value), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_tt", i), 32'(tick), 32'(vecs[i].et));
         chk($sformatf("vec%0d_tu", i), 32'(upd_count), 32'(vecs[i].eu));
      end

      // period 10 invert: updates on edges 10 and 20
      do_reset("p10_rst");
      for (int k = 1; k <= 20; k++) begin
         cycle($sformatf("p10_e%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
         chk($sformatf("p10_e%0d_cv", k), 32'(value), (k < 10) ? 32'h5 : (k < 20) ? 32'hA : 32'h5);
         chk($sformatf("p10_e%0d_ct", k), 32'(tick), (k % 10 == 0) ? 32'd1 : 32'd0);
      end
      chk("p10_cu", 32'(upd_count), 32'd2);

      // increment, period 2, upd_count wrap after 256 updates
      do_reset("inc_rst");
      cycle("inc_ld", 1'b0, 1'b1, 1'b1, 8'd2, 2'b10, 4'hE);
      for (int k = 1; k <= 512; k++) begin
         cycle($sformatf("inc_e%0d", k), 1'b0, 1'b1, 1'b0, 8'd2, 2'b10, 4'h0);
         if (k == 2) chk("inc_e2_cv", 32'(value), 32'hF);
         if (k == 4) begin
            chk("inc_e4_cv", 32'(value), 32'h0);
            chk("inc_e4_cu", 32'(upd_count), 32'd2);
         end
         if (k == 510) chk("inc_255_cu", 32'(upd_count), 32'd255);
      end
      chk("inc_wrap_cu", 32'(upd_count), 32'd0);
      chk("inc_wrap_cv", 32'(value), 32'hE);

      // en pause of 5 cycles at cnt=4: update on edge 15
      do_reset("pause_rst");
      for (int k = 1; k <= 15; k++) begin
         cycle($sformatf("pause_e%0d", k), 1'b0, !(k >= 5 && k <= 9), 1'b0, 8'd10, 2'b00, 4'h0);
         chk($sformatf("pause_e%0d_cv", k), 32'(value), (k == 15) ? 32'hA : 32'h5);
         chk($sformatf("pause_e%0d_ct", k), 32'(tick), (k == 15) ? 32'd1 : 32'd0);
      end

      // load on terminal edge, then period shrink 10->3 at cnt=6
      do_reset("ldt_rst");
      for (int k = 1; k <= 9; k++)
         cycle($sformatf("ldt_e%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
      cycle("ldt_load", 1'b0, 1'b1, 1'b1, 8'd10, 2'b00, 4'h3);
      chk("ldt_load_cv", 32'(value), 32'h3);
      chk("ldt_load_ct", 32'(tick), 32'd0);
      chk("ldt_load_cu", 32'(upd_count), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         cycle($sformatf("ldt_n%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
         chk($sformatf("ldt_n%0d_ct", k), 32'(tick), (k == 10) ? 32'd1 : 32'd0);
      end
      chk("ldt_n10_cv", 32'(value), 32'hC);
      for (int k = 1; k <= 6; k++)
         cycle($sformatf("shr_e%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
      cycle("shr_p3", 1'b0, 1'b1, 1'b0, 8'd3, 2'b00, 4'h0);
      chk("shr_p3_ct", 32'(tick), 32'd1);
      chk("shr_p3_cv", 32'(value), 32'h3);
      chk("shr_p3_cu", 32'(upd_count), 32'd2);

      // reset mid-period at cnt=7 discards the partial count
      do_reset("mid_rst0");
      for (int k = 1; k <= 7; k++)
         cycle($sformatf("mid_e%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
      cycle("mid_rst", 1'b1, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
      chk("mid_rst_cv", 32'(value), 32'h5);
      chk("mid_rst_cu", 32'(upd_count), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         cycle($sformatf("mid_n%0d", k), 1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 4'h0);
         chk($sformatf("mid_n%0d_ct", k), 32'(tick), (k == 10) ? 32'd1 : 32'd0);
      end
      chk("mid_n10_cv", 32'(value), 32'hA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
